// File: rtl/stack_machine_multi_accel_adapter_pkg.sv
// Shared encodings, marker words and width helpers for the multi-lane stack-machine adapter.
package stack_machine_pkg;

    localparam int unsigned ACCEL_W    = 16;
    localparam logic [15:0] END_MARKER = 16'hFFFF;
    localparam logic [15:0] SKIP_WORD  = 16'hFFFF;

    typedef enum logic [1:0] {
        S_LOAD_TYPE,
        S_LOAD_INT,
        S_LOAD_FRAC,
        S_RUN
    } top_state_e;

    typedef enum logic [1:0] {
        L_IDLE,
        L_START,
        L_BUSY,
        L_DONE
    } lane_state_e;

    function automatic int unsigned number_width(input int unsigned int_w, input int unsigned frac_w);
        return int_w + frac_w;
    endfunction

    // Queue item carries a one-bit type ahead of the fixed-point number.
    function automatic int unsigned item_width(input int unsigned int_w, input int unsigned frac_w);
        return number_width(int_w, frac_w) + 1;
    endfunction

    function automatic int unsigned queue_index_width(input int unsigned size);
        return (size > 1) ? $clog2(size) : 1;
    endfunction

    function automatic int unsigned queue_length_width(input int unsigned size);
        return $clog2(size + 1);
    endfunction

endpackage

// File: rtl/stack_machine_multi_accel_adapter_if.sv
// 16-bit accelerator word port: host (master) writes program/X words, reads Y words.
interface stack_machine_multi_accel_adapter_if;
    logic        accel_can_read;
    logic        accel_can_write;
    logic        accel_read_enable;
    logic        accel_write_enable;
    logic [15:0] accel_read_data;
    logic [15:0] accel_write_data;

    modport master (
        input  accel_can_read, accel_can_write, accel_read_data,
        output accel_read_enable, accel_write_enable, accel_write_data
    );

    modport slave (
        output accel_can_read, accel_can_write, accel_read_data,
        input  accel_read_enable, accel_write_enable, accel_write_data
    );
endinterface

// File: rtl/stack_machine_multi_accel_adapter_lane_ctrl.sv
// Per-lane IDLE/START/BUSY/DONE sequencer holding the lane's X and the captured Y/skip result.
module stack_machine_lane_ctrl
    import stack_machine_pkg::*;
#(
    parameter int unsigned X_WIDTH = 10,
    parameter int unsigned Y_WIDTH = 9
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               accept_i,
    input  logic [X_WIDTH-1:0] x_i,
    input  logic               read_i,
    input  logic               sm_ready_i,
    input  logic [Y_WIDTH-1:0] sm_y_i,
    input  logic               sm_skip_i,
    output logic               sm_start_o,
    output logic [X_WIDTH-1:0] sm_x_o,
    output logic               idle_o,
    output logic               done_o,
    output logic [Y_WIDTH-1:0] y_o,
    output logic               skip_o
);

    lane_state_e        state_q;
    logic [X_WIDTH-1:0] x_q;
    logic [Y_WIDTH-1:0] y_q;
    logic               skip_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= L_IDLE;
            x_q     <= '0;
            y_q     <= '0;
            skip_q  <= 1'b0;
        end else begin
            unique case (state_q)
                L_IDLE: if (accept_i) begin
                    x_q     <= x_i;
                    state_q <= L_START;
                end
                // sm_ready is deliberately ignored while the start pulse is out.
                L_START: state_q <= L_BUSY;
                L_BUSY: if (sm_ready_i) begin
                    y_q     <= sm_y_i;
                    skip_q  <= sm_skip_i;
                    state_q <= L_DONE;
                end
                L_DONE: if (read_i) state_q <= L_IDLE;
                default: state_q <= L_IDLE;
            endcase
        end
    end

    assign sm_start_o = (state_q == L_START);
    assign sm_x_o     = x_q;
    assign idle_o     = (state_q == L_IDLE);
    assign done_o     = (state_q == L_DONE);
    assign y_o        = y_q;
    assign skip_o     = skip_q;

endmodule

// File: rtl/stack_machine_multi_accel_adapter.sv
// Loads a shared program into the item queue, then dispatches X words round-robin to the lanes
// and returns Y words strictly in X order.
module stack_machine_multi_accel_adapter
    import stack_machine_pkg::*;
#(
    parameter int unsigned LANES                 = 4,
    parameter int unsigned INTEGER_PART_WIDTH    = 8,
    parameter int unsigned FRACTIONAL_PART_WIDTH = 8,
    parameter int unsigned OUTPUT_QUEUE_SIZE     = 64,
    parameter int unsigned HOR_ACTIVE_PIXELS     = 640,
    parameter int unsigned VER_ACTIVE_PIXELS     = 480
) (
    input  logic clk,
    input  logic rst,
    stack_machine_multi_accel_adapter_if.slave accel,
    output logic [LANES-1:0] sm_start,
    input  logic [LANES-1:0] sm_ready,
    output logic [LANES*$clog2(HOR_ACTIVE_PIXELS)-1:0] sm_x_input,
    input  logic [LANES*$clog2(VER_ACTIVE_PIXELS)-1:0] sm_y_output,
    input  logic [LANES-1:0] sm_skip_pixel,
    input  logic [LANES*queue_index_width(OUTPUT_QUEUE_SIZE)-1:0] sm_output_queue_index,
    input  logic [LANES-1:0] sm_output_queue_get,
    output logic [LANES*item_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH)-1:0] sm_output_queue_data_out,
    output logic [queue_length_width(OUTPUT_QUEUE_SIZE)-1:0] sm_output_queue_length,
    output logic sm_output_queue_ready,
    output logic overflow
);

    localparam int unsigned X_W    = $clog2(HOR_ACTIVE_PIXELS);
    localparam int unsigned Y_W    = $clog2(VER_ACTIVE_PIXELS);
    localparam int unsigned QI_W   = queue_index_width(OUTPUT_QUEUE_SIZE);
    localparam int unsigned LEN_W  = queue_length_width(OUTPUT_QUEUE_SIZE);
    localparam int unsigned ITEM_W = item_width(INTEGER_PART_WIDTH, FRACTIONAL_PART_WIDTH);
    localparam int unsigned PTR_W  = (LANES > 1) ? $clog2(LANES) : 1;

    top_state_e                    state_q;
    logic                          type_q;
    logic [INTEGER_PART_WIDTH-1:0] int_q;
    logic [LEN_W-1:0]              length_q;
    logic                          overflow_q;
    logic [PTR_W-1:0]              disp_ptr_q;
    logic [PTR_W-1:0]              rd_ptr_q;
    logic [ITEM_W-1:0]             queue_q [OUTPUT_QUEUE_SIZE];
    logic [ITEM_W-1:0]             qdata_q [LANES];

    logic [LANES-1:0] lane_idle, lane_done, lane_skip, lane_accept, lane_read;
    logic [Y_W-1:0]   lane_y [LANES];
    logic             wr_fire, rd_fire, is_end, all_idle, queue_full;
    logic [ITEM_W-1:0] new_item;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(LANES - 1)) ? '0 : PTR_W'(p + 1'b1);
    endfunction

    assign is_end     = (accel.accel_write_data == END_MARKER);
    assign all_idle   = &lane_idle;
    assign queue_full = (length_q == LEN_W'(OUTPUT_QUEUE_SIZE));
    assign new_item   = {type_q, int_q, accel.accel_write_data[FRACTIONAL_PART_WIDTH-1:0]};

    // End-of-frame is only taken once every lane has drained; looks at the live write word.
    always_comb begin
        accel.accel_can_write = 1'b1;
        if (state_q == S_RUN) begin
            accel.accel_can_write = lane_idle[disp_ptr_q] && (!is_end || all_idle);
        end
    end

    assign accel.accel_can_read  = lane_done[rd_ptr_q];
    assign accel.accel_read_data = lane_skip[rd_ptr_q] ? SKIP_WORD : ACCEL_W'(lane_y[rd_ptr_q]);
    assign wr_fire = accel.accel_write_enable && accel.accel_can_write;
    assign rd_fire = accel.accel_read_enable && accel.accel_can_read;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_LOAD_TYPE;
            type_q     <= 1'b0;
            int_q      <= '0;
            length_q   <= '0;
            overflow_q <= 1'b0;
            disp_ptr_q <= '0;
            rd_ptr_q   <= '0;
        end else begin
            if (rd_fire) rd_ptr_q <= next_ptr(rd_ptr_q);
            if (wr_fire) begin
                unique case (state_q)
                    S_LOAD_TYPE: begin
                        type_q  <= accel.accel_write_data[0];
                        state_q <= accel.accel_write_data[1] ? S_LOAD_INT : S_RUN;
                    end
                    S_LOAD_INT: begin
                        int_q   <= accel.accel_write_data[INTEGER_PART_WIDTH-1:0];
                        state_q <= S_LOAD_FRAC;
                    end
                    S_LOAD_FRAC: begin
                        if (queue_full) overflow_q <= 1'b1;
                        else            length_q   <= LEN_W'(length_q + 1'b1);
                        state_q <= S_LOAD_TYPE;
                    end
                    S_RUN: begin
                        if (is_end) begin
                            length_q   <= '0;
                            overflow_q <= 1'b0;
                            state_q    <= S_LOAD_TYPE;
                        end else begin
                            disp_ptr_q <= next_ptr(disp_ptr_q);
                        end
                    end
                    default: state_q <= S_LOAD_TYPE;
                endcase
            end
        end
    end

    // Program storage has no reset; only [0, length) is ever meaningful.
    always_ff @(posedge clk) begin
        if (wr_fire && state_q == S_LOAD_FRAC && !queue_full) begin
            queue_q[length_q[QI_W-1:0]] <= new_item;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int unsigned i = 0; i < LANES; i++) qdata_q[i] <= '0;
        end else begin
            for (int unsigned i = 0; i < LANES; i++) begin
                if (sm_output_queue_get[i]) qdata_q[i] <= queue_q[sm_output_queue_index[i*QI_W +: QI_W]];
            end
        end
    end

    for (genvar g = 0; g < LANES; g++) begin : g_lane
        assign lane_accept[g] = wr_fire && (state_q == S_RUN) && !is_end && (disp_ptr_q == PTR_W'(g));
        assign lane_read[g]   = rd_fire && (rd_ptr_q == PTR_W'(g));
        assign sm_output_queue_data_out[g*ITEM_W +: ITEM_W] = qdata_q[g];

        stack_machine_lane_ctrl #(
            .X_WIDTH (X_W),
            .Y_WIDTH (Y_W)
        ) u_lane (
            .clk        (clk),
            .rst        (rst),
            .accept_i   (lane_accept[g]),
            .x_i        (accel.accel_write_data[X_W-1:0]),
            .read_i     (lane_read[g]),
            .sm_ready_i (sm_ready[g]),
            .sm_y_i     (sm_y_output[g*Y_W +: Y_W]),
            .sm_skip_i  (sm_skip_pixel[g]),
            .sm_start_o (sm_start[g]),
            .sm_x_o     (sm_x_input[g*X_W +: X_W]),
            .idle_o     (lane_idle[g]),
            .done_o     (lane_done[g]),
            .y_o        (lane_y[g]),
            .skip_o     (lane_skip[g])
        );
    end

    assign sm_output_queue_length = length_q;
    assign sm_output_queue_ready  = 1'b1;
    assign overflow               = overflow_q;

endmodule

// File: tb/tb_stack_machine_multi_accel_adapter.sv
// Directed bench for the 4-lane adapter: program load, in-order results, skip, overflow, drain, reset.
module tb_stack_machine_multi_accel_adapter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  sm_start;
    logic [3:0]  sm_ready = '0;
    logic [39:0] sm_x_input;
    logic [35:0] sm_y_output = '0;
    logic [3:0]  sm_skip_pixel = '0;
    logic [23:0] sm_qidx = '0;
    logic [3:0]  sm_qget = '0;
    logic [67:0] sm_qdata;
    logic [6:0]  sm_qlen;
    logic        sm_qready;
    logic        overflow;

    int checks = 0;
    int errors = 0;

    stack_machine_multi_accel_adapter_if acc_if ();

    stack_machine_multi_accel_adapter dut (
        .clk                      (clk),
        .rst                      (rst),
        .accel                    (acc_if),
        .sm_start                 (sm_start),
        .sm_ready                 (sm_ready),
        .sm_x_input               (sm_x_input),
        .sm_y_output              (sm_y_output),
        .sm_skip_pixel            (sm_skip_pixel),
        .sm_output_queue_index    (sm_qidx),
        .sm_output_queue_get      (sm_qget),
        .sm_output_queue_data_out (sm_qdata),
        .sm_output_queue_length   (sm_qlen),
        .sm_output_queue_ready    (sm_qready),
        .overflow                 (overflow)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [16:0] qd(input int i);
        return sm_qdata[i*17 +: 17];
    endfunction

    function automatic logic [9:0] xin(input int i);
        return sm_x_input[i*10 +: 10];
    endfunction

    task automatic set_y(input int lane, input int val);
        sm_y_output[lane*9 +: 9] = 9'(val);
    endtask

    task automatic host_write(input logic [15:0] d);
        acc_if.accel_write_data   = d;
        acc_if.accel_write_enable = 1'b1;
        #1;
        for (int n = 0; n < 20 && !acc_if.accel_can_write; n++) begin
            @(posedge clk);
            #2;
        end
        if (!acc_if.accel_can_write) check_eq("wr_timeout", 32'(acc_if.accel_can_write), 32'd1);
        @(posedge clk);
        #1;
        acc_if.accel_write_enable = 1'b0;
    endtask

    task automatic host_read(input string tag, input logic [15:0] exp);
        check_eq({tag, "_vld"}, 32'(acc_if.accel_can_read), 32'd1);
        check_eq(tag, 32'(acc_if.accel_read_data), 32'(exp));
        acc_if.accel_read_enable = 1'b1;
        tick();
        acc_if.accel_read_enable = 1'b0;
    endtask

    initial begin
        acc_if.accel_read_enable  = 1'b0;
        acc_if.accel_write_enable = 1'b0;
        acc_if.accel_write_data   = '0;
        repeat (3) @(posedge clk);
        #1;
        check_eq("rst_can_read", 32'(acc_if.accel_can_read), 32'd0);
        check_eq("rst_can_write", 32'(acc_if.accel_can_write), 32'd1);
        check_eq("rst_len", 32'(sm_qlen), 32'd0);
        check_eq("rst_ovf", 32'(overflow), 32'd0);
        check_eq("rst_start", 32'(sm_start), 32'd0);
        check_eq("rst_x", 32'(sm_x_input[31:0]), 32'd0);
        check_eq("q_ready", 32'(sm_qready), 32'd1);
        rst = 1'b0;
        tick();

        // Three-item program; upper bits of int/frac words must be masked off.
        host_write(16'h0003); host_write(16'hA512); host_write(16'h5A34);
        host_write(16'h0002); host_write(16'h00AB); host_write(16'h00CD);
        host_write(16'h0003); host_write(16'h00FF); host_write(16'h0001);
        host_write(16'h0000);
        check_eq("len3", 32'(sm_qlen), 32'd3);
        check_eq("ovf3", 32'(overflow), 32'd0);

        sm_qidx = {6'd1, 6'd2, 6'd1, 6'd0};
        sm_qget = 4'b0111;
        tick();
        check_eq("q0", 32'(qd(0)), 32'h11234);
        check_eq("q1", 32'(qd(1)), 32'h0ABCD);
        check_eq("q2", 32'(qd(2)), 32'h1FF01);
        check_eq("q3_noget", 32'(qd(3)), 32'h0);
        sm_qget = '0;
        sm_qidx = {6'd0, 6'd0, 6'd0, 6'd2};
        tick();
        check_eq("q0_hold", 32'(qd(0)), 32'h11234);

        // Round 1: X 0..3, lanes finish in reverse order, lane 2 skips.
        for (int x = 0; x < 4; x++) begin
            set_y(x, x * 3 + 5);
            host_write(16'(x));
        end
        sm_skip_pixel = 4'b0100;
        for (int i = 0; i < 4; i++) check_eq("x_lane", 32'(xin(i)), 32'(i));
        acc_if.accel_write_data = 16'd4;
        #1;
        check_eq("cw_busy", 32'(acc_if.accel_can_write), 32'd0);
        sm_ready = 4'b1000; tick();
        check_eq("cr_wait3", 32'(acc_if.accel_can_read), 32'd0);
        sm_ready = 4'b1100; tick();
        sm_ready = 4'b1110; tick();
        check_eq("cr_wait1", 32'(acc_if.accel_can_read), 32'd0);
        sm_ready = 4'b1111; tick();
        host_read("r0", 16'd5);
        host_read("r1", 16'd8);
        host_read("r2_skip", 16'hFFFF);
        host_read("r3", 16'd14);

        // Round 2: X 4..7, again reverse completion, no skips.
        sm_ready = '0;
        sm_skip_pixel = '0;
        for (int x = 4; x < 8; x++) begin
            set_y(x - 4, x * 3 + 5);
            host_write(16'(x));
        end
        for (int i = 3; i >= 0; i--) begin
            sm_ready[i] = 1'b1;
            tick();
        end
        host_read("r4", 16'd17);
        host_read("r5", 16'd20);
        host_read("r6", 16'd23);
        host_read("r7", 16'd26);
        check_eq("cr_empty", 32'(acc_if.accel_can_read), 32'd0);

        // End marker must wait until every lane has drained.
        sm_ready = '0;
        set_y(0, 29); set_y(1, 32);
        host_write(16'd8);
        host_write(16'd9);
        sm_ready = 4'b0001; tick();
        acc_if.accel_write_data   = 16'hFFFF;
        acc_if.accel_write_enable = 1'b1;
        #1;
        check_eq("end_blk0", 32'(acc_if.accel_can_write), 32'd0);
        host_read("r8", 16'd29);
        check_eq("end_blk1", 32'(acc_if.accel_can_write), 32'd0);
        sm_ready = 4'b0011; tick();
        check_eq("end_blk_done", 32'(acc_if.accel_can_write), 32'd0);
        host_read("r9", 16'd32);
        check_eq("end_ok", 32'(acc_if.accel_can_write), 32'd1);
        tick();
        acc_if.accel_write_enable = 1'b0;
        check_eq("end_len", 32'(sm_qlen), 32'd0);

        // Empty program, sm_ready held high: one start pulse, DONE two edges after accept.
        host_write(16'h0000);
        sm_ready = 4'b1111;
        set_y(2, 35);
        host_write(16'd10);
        check_eq("rh_start", 32'(sm_start), 32'b0100);
        check_eq("rh_cr_n1", 32'(acc_if.accel_can_read), 32'd0);
        tick();
        check_eq("rh_start_off", 32'(sm_start), 32'd0);
        check_eq("rh_cr_busy", 32'(acc_if.accel_can_read), 32'd0);
        tick();
        check_eq("rh_start_off2", 32'(sm_start), 32'd0);
        host_read("r10", 16'd35);
        check_eq("rh_start_idle", 32'(sm_start), 32'd0);

        // Overflow: 65 items into a 64-entry queue.
        host_write(16'hFFFF);
        for (int k = 0; k < 65; k++) begin
            if (k == 64) begin
                check_eq("ovf_len64_pre", 32'(sm_qlen), 32'd64);
                check_eq("ovf_pre", 32'(overflow), 32'd0);
            end
            host_write(16'h0002 | 16'(k[0]));
            host_write(16'(k));
            host_write(16'(8'(k) ^ 8'hFF));
        end
        check_eq("ovf_len64", 32'(sm_qlen), 32'd64);
        check_eq("ovf_set", 32'(overflow), 32'd1);
        host_write(16'h0000);
        sm_qidx = {6'd0, 6'd1, 6'd0, 6'd63};
        sm_qget = 4'b0111;
        tick();
        sm_qget = '0;
        check_eq("ovf_q63", 32'(qd(0)), 32'h13FC0);
        check_eq("ovf_q0", 32'(qd(1)), 32'h000FF);
        check_eq("ovf_q1", 32'(qd(2)), 32'h101FE);
        host_write(16'hFFFF);
        check_eq("ovf_clr_len", 32'(sm_qlen), 32'd0);
        check_eq("ovf_clr", 32'(overflow), 32'd0);

        // Reset while three lanes are busy.
        host_write(16'h0000);
        sm_ready = '0;
        host_write(16'd1);
        host_write(16'd2);
        host_write(16'd3);
        check_eq("pre_rst_x", 32'(xin(1)), 32'd3);
        rst = 1'b1;
        #1;
        check_eq("arst_can_read", 32'(acc_if.accel_can_read), 32'd0);
        check_eq("arst_can_write", 32'(acc_if.accel_can_write), 32'd1);
        check_eq("arst_start", 32'(sm_start), 32'd0);
        check_eq("arst_x_lo", 32'(sm_x_input[31:0]), 32'd0);
        check_eq("arst_x_hi", 32'(sm_x_input[39:32]), 32'd0);
        check_eq("arst_qdata", 32'(qd(0)), 32'd0);
        check_eq("arst_len", 32'(sm_qlen), 32'd0);
        tick();
        check_eq("arst_start_hold", 32'(sm_start), 32'd0);
        rst = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1);
    end

endmodule
